fft_bfly_r2: RTL

- Pipelined radix-2 DIT butterfly stage for the FFT datapath.
- Takes complex pair A, B and a complex 8-bit twiddle W, forms B·W with four 17x8 fractional products, then outputs A+B·W and A−B·W.
- Sits directly downstream of the 17x8 fractional multiplier function and feeds the next stage or the output reorder buffer.
- Valid/ready streaming interface; counts butterflies per stage frame and flags the last one.

---
 rtl/fft_bfly_r2.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fft_bfly_r2.sv
// Three-stage radix-2 DIT butterfly: X0 = A + B*W, X1 = A - B*W.
// Define BFLY_SCALE_EN to halve both results with round-half-up.
module fft_bfly_r2 #(
    parameter int N_BFLY = 8,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16:0]      a_re,
    input  logic [16:0]      a_im,
    input  logic [16:0]      b_re,
    input  logic [16:0]      b_im,
    input  logic [7:0]       w_re,
    input  logic [7:0]       w_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [17:0]      x0_re,
    output logic [17:0]      x0_im,
    output logic [17:0]      x1_re,
    output logic [17:0]      x1_im,
    output logic             out_last,
    output logic [CNT_W-1:0] bfly_idx
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BFLY - 1);

    // Sign-magnitude product so the fraction truncates toward zero.
    function automatic logic [16:0] pmul(input logic [16:0] x,
                                         input logic [7:0]  w);
        logic [16:0] ax;
        logic [7:0]  aw;
        logic [24:0] pr;
        logic [16:0] q;
        ax = x[16] ? (~x + 17'd1) : x;
        aw = w[7] ? (~w + 8'd1) : w;
        pr = 25'(ax) * 25'(aw);
        q  = 17'(pr >> 7);
        return (x[16] ^ w[7]) ? (~q + 17'd1) : q;
    endfunction

    function automatic logic [17:0] fin(input logic [18:0] s);
        logic [18:0] t;
`ifdef BFLY_SCALE_EN
        t = 19'($signed(s + 19'd1) >>> 1);
`else
        t = s;
`endif
        return 18'(t);
    endfunction

    logic        v1_q, v2_q, v3_q;
    logic [16:0] a_re1_q, a_im1_q, b_re1_q, b_im1_q;
    logic [7:0]  w_re1_q, w_im1_q;
    logic [16:0] a_re2_q, a_im2_q;
    logic [17:0] m_re_q, m_im_q, m_re_d, m_im_d;
    logic [17:0] x0_re_q, x0_im_q, x1_re_q, x1_im_q;
    logic [17:0] x0_re_d, x0_im_d, x1_re_d, x1_im_d;
    logic [16:0] p_rr, p_ii, p_ri, p_ir;
    logic [18:0] ar19, ai19, mr19, mi19;
    logic [CNT_W-1:0] idx_q;
    logic        adv;

    assign adv = !v3_q || out_ready;

    always_comb begin
        p_rr   = pmul(b_re1_q, w_re1_q);
        p_ii   = pmul(b_im1_q, w_im1_q);
        p_ri   = pmul(b_re1_q, w_im1_q);
        p_ir   = pmul(b_im1_q, w_re1_q);
        m_re_d = {p_rr[16], p_rr} - {p_ii[16], p_ii};
        m_im_d = {p_ri[16], p_ri} + {p_ir[16], p_ir};
    end

    always_comb begin
        ar19    = {{2{a_re2_q[16]}}, a_re2_q};
        ai19    = {{2{a_im2_q[16]}}, a_im2_q};
        mr19    = {m_re_q[17], m_re_q};
        mi19    = {m_im_q[17], m_im_q};
        x0_re_d = fin(ar19 + mr19);
        x0_im_d = fin(ai19 + mi19);
        x1_re_d = fin(ar19 - mr19);
        x1_im_d = fin(ai19 - mi19);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            a_re1_q <= '0;
            a_im1_q <= '0;
            b_re1_q <= '0;
            b_im1_q <= '0;
            w_re1_q <= '0;
            w_im1_q <= '0;
            a_re2_q <= '0;
            a_im2_q <= '0;
            m_re_q  <= '0;
            m_im_q  <= '0;
            x0_re_q <= '0;
            x0_im_q <= '0;
            x1_re_q <= '0;
            x1_im_q <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                a_re1_q <= a_re;
                a_im1_q <= a_im;
                b_re1_q <= b_re;
                b_im1_q <= b_im;
                w_re1_q <= w_re;
                w_im1_q <= w_im;
            end
            a_re2_q <= a_re1_q;
            a_im2_q <= a_im1_q;
            m_re_q  <= m_re_d;
            m_im_q  <= m_im_d;
            x0_re_q <= x0_re_d;
            x0_im_q <= x0_im_d;
            x1_re_q <= x1_re_d;
            x1_im_q <= x1_im_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (v3_q && out_ready) begin
            idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign x0_re     = x0_re_q;
    assign x0_im     = x0_im_q;
    assign x1_re     = x1_re_q;
    assign x1_im     = x1_im_q;
    assign bfly_idx  = idx_q;
    assign out_last  = v3_q && (idx_q == LAST);

endmodule
